// File: rtl/fetch_controller_pkg.sv
// Shared fetch-stage definitions: word width, default PC increment,
// fetch FSM encoding and PC arithmetic.
package fetch_controller_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] PC_STEP_DEFAULT = 16'd2;

  typedef enum logic [1:0] {
    FETCH_FILL = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_SKID = 2'd2
  } fetch_state_e;

  // Unsigned add that wraps modulo 2^WORD_W.
  function automatic logic [WORD_W-1:0] pc_add(
    input logic [WORD_W-1:0] pc,
    input logic [WORD_W-1:0] step
  );
    pc_add = pc + step;
  endfunction

endpackage

// File: rtl/fetch_controller_skid_buf.sv
// One-entry holding register for an instruction word and its address,
// with clear taking priority over load.
module fetch_skid_buf
  import fetch_controller_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [WORD_W-1:0] pc_i,
  output logic [WORD_W-1:0] data_o,
  output logic [WORD_W-1:0] pc_o
);

  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] data_d;
  logic [WORD_W-1:0] pc_d;

  // Next-state selection for the held entry.
  always_comb begin
    data_d = data_q;
    pc_d   = pc_q;
    if (clear_i) begin
      data_d = {WORD_W{1'b0}};
      pc_d   = {WORD_W{1'b0}};
    end else if (load_i) begin
      data_d = data_i;
      pc_d   = pc_i;
    end else begin
      data_d = data_q;
      pc_d   = pc_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= {WORD_W{1'b0}};
      pc_q   <= {WORD_W{1'b0}};
    end else begin
      data_q <= data_d;
      pc_q   <= pc_d;
    end
  end

  assign data_o = data_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives a one-cycle synchronous
// instruction memory, and hands instructions to decode through a skid entry.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
  parameter logic [WORD_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic [WORD_W-1:0] imem_data_i,
  output logic [WORD_W-1:0] ir_o,
  output logic [WORD_W-1:0] ir_pc_o,
  output logic [WORD_W-1:0] ir_npc_o,
  output logic              ir_valid_o
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;
  logic [WORD_W-1:0] inflight_pc_q;
  logic [WORD_W-1:0] ir_q;
  logic [WORD_W-1:0] ir_d;
  logic [WORD_W-1:0] ir_pc_q;
  logic [WORD_W-1:0] ir_pc_d;
  logic              ir_valid_q;
  logic              ir_valid_d;

  logic              skid_load_s;
  logic              skid_clear_s;
  logic [WORD_W-1:0] skid_ir_s;
  logic [WORD_W-1:0] skid_pc_s;

  fetch_skid_buf u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (skid_clear_s),
    .load_i  (skid_load_s),
    .data_i  (imem_data_i),
    .pc_i    (inflight_pc_q),
    .data_o  (skid_ir_s),
    .pc_o    (skid_pc_s)
  );

  // Fetch FSM next state and datapath selection; redirect overrides stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    if (redirect_i) begin
      pc_d         = redirect_pc_i;
      state_d      = FETCH_FILL;
      ir_valid_d   = 1'b0;
      skid_clear_s = 1'b1;
    end else begin
      case (state_q)
        FETCH_FILL: begin
          // First word is now in flight; stall cannot matter until it returns.
          pc_d    = pc_add(pc_q, PC_STEP);
          state_d = FETCH_RUN;
        end
        FETCH_RUN: begin
          if (stall_i) begin
            skid_load_s = 1'b1;
            state_d     = FETCH_SKID;
          end else begin
            ir_d       = imem_data_i;
            ir_pc_d    = inflight_pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_add(pc_q, PC_STEP);
          end
        end
        FETCH_SKID: begin
          // Memory has been re-reading pc_q, so the word after the skid entry
          // arrives on the cycle following release.
          if (stall_i) begin
            state_d = FETCH_SKID;
          end else begin
            ir_d       = skid_ir_s;
            ir_pc_d    = skid_pc_s;
            ir_valid_d = 1'b1;
            pc_d       = pc_add(pc_q, PC_STEP);
            state_d    = FETCH_RUN;
          end
        end
        default: begin
          state_d      = FETCH_FILL;
          ir_valid_d   = 1'b0;
          skid_clear_s = 1'b1;
        end
      endcase
    end
  end

  // State, PC and decode-facing registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= FETCH_FILL;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      ir_q          <= {WORD_W{1'b0}};
      ir_pc_q       <= {WORD_W{1'b0}};
      ir_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= pc_q;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign ir_o        = ir_q;
  assign ir_pc_o     = ir_pc_q;
  assign ir_npc_o    = pc_add(ir_pc_q, PC_STEP);
  assign ir_valid_o  = ir_valid_q;

endmodule
